// File: rtl/tt_pin_pkg.sv
// Pin-level constants and FSM encoding for the host side of the tile's
// byte-parallel 4-phase pin protocol.
package tt_pin_pkg;

  // uio bit positions: host-driven bits
  localparam int unsigned MSG_REQ  = 0;
  localparam int unsigned FIRST    = 1;
  localparam int unsigned LAST     = 2;
  localparam int unsigned PAD      = 6;
  localparam int unsigned HASH_ACK = 7;

  // uio bit positions: DUT-driven bits (bit 5 is reserved)
  localparam int unsigned MSG_ACK  = 3;
  localparam int unsigned HASH_REQ = 4;

  // Output-enable mask: host owns bits 0,1,2,6,7
  localparam logic [7:0] UIO_OE = 8'b1100_0111;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_SEND_REQ  = 3'd2,
    ST_SEND_REL  = 3'd3,
    ST_HASH_WAIT = 3'd4,
    ST_HASH_ACK  = 3'd5
  } state_t;

endpackage

// File: rtl/tt_host_driver_sync_ff.sv
// Single-bit multi-stage synchronizer for DUT-driven handshake lines.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the asynchronous input through STAGES flops, clearing on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= (chain << 1) | STAGES'(d);
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/tt_host_driver.sv
// Host-side initiator: streams message bytes to the tile over a 4-phase
// msg_req/msg_ack handshake, zero-pads the final block, then collects the
// digest over a hash_req/hash_ack handshake onto a local byte stream.
module tt_host_driver
  import tt_pin_pkg::*;
#(
  parameter int unsigned BLOCK_B     = 64,
  parameter int unsigned HASH_B      = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_W   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid_i,
  output logic       s_ready_o,
  input  logic [7:0] s_data_i,
  input  logic       s_last_i,
  output logic       m_valid_o,
  output logic [7:0] m_data_o,
  output logic       m_last_o,
  output logic [7:0] dut_ui_o,
  input  logic [7:0] dut_uo_i,
  output logic [7:0] dut_uio_o,
  output logic [7:0] dut_uio_oe_o,
  input  logic [7:0] dut_uio_i,
  output logic       busy_o,
  output logic       timeout_o
);

  localparam int unsigned BW = (BLOCK_B > 1) ? $clog2(BLOCK_B) : 1;
  localparam int unsigned HW = (HASH_B > 1) ? $clog2(HASH_B) : 1;
  localparam logic [BW-1:0] BYTE_LAST = BW'(BLOCK_B - 1);
  localparam logic [HW-1:0] HASH_LAST = HW'(HASH_B - 1);

  state_t state_q, state_d;

  logic [7:0]           ui_q, ui_d;
  logic                 first_q, first_d;
  logic                 last_q, last_d;
  logic                 pad_q, pad_d;
  logic                 msg_req_q, msg_req_d;
  logic                 hash_ack_q, hash_ack_d;
  logic [BW-1:0]        byte_idx_q, byte_idx_d;
  logic [HW-1:0]        hash_idx_q, hash_idx_d;
  logic [7:0]           m_data_q, m_data_d;
  logic                 m_valid_q, m_valid_d;
  logic                 m_last_q, m_last_d;
  logic                 timeout_q, timeout_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;

  logic msg_ack_s;
  logic hash_req_s;
  logic counting;
  logic [7:0] uio_bus;
  logic unused_uio;

  // Only msg_ack and hash_req are read back; the rest of the bus is ignored.
  assign unused_uio = ^{dut_uio_i[7:5], dut_uio_i[2:0]};

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_msg_ack (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dut_uio_i[MSG_ACK]),
    .q     (msg_ack_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_hash_req (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dut_uio_i[HASH_REQ]),
    .q     (hash_req_s)
  );

  assign counting = (state_q == ST_SEND_REQ)  || (state_q == ST_SEND_REL) ||
                    (state_q == ST_HASH_WAIT) || (state_q == ST_HASH_ACK);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered pin drivers, counters, digest stream and watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ui_q       <= '0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      pad_q      <= 1'b0;
      msg_req_q  <= 1'b0;
      hash_ack_q <= 1'b0;
      byte_idx_q <= '0;
      hash_idx_q <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      timeout_q  <= 1'b0;
      wd_q       <= '0;
    end else begin
      ui_q       <= ui_d;
      first_q    <= first_d;
      last_q     <= last_d;
      pad_q      <= pad_d;
      msg_req_q  <= msg_req_d;
      hash_ack_q <= hash_ack_d;
      byte_idx_q <= byte_idx_d;
      hash_idx_q <= hash_idx_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      timeout_q  <= timeout_d;
      wd_q       <= wd_d;
    end
  end

  // Next-state and next-register logic; watchdog expiry overrides everything.
  always_comb begin
    state_d    = state_q;
    ui_d       = ui_q;
    first_d    = first_q;
    last_d     = last_q;
    pad_d      = pad_q;
    msg_req_d  = msg_req_q;
    hash_ack_d = hash_ack_q;
    byte_idx_d = byte_idx_q;
    hash_idx_d = hash_idx_q;
    m_data_d   = m_data_q;
    m_valid_d  = 1'b0;
    m_last_d   = m_last_q;
    timeout_d  = timeout_q;
    wd_d       = '0;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (s_valid_i) begin
          ui_d      = s_data_i;
          first_d   = (byte_idx_q == '0);
          last_d    = s_last_i;
          pad_d     = 1'b0;
          msg_req_d = 1'b1;
          timeout_d = 1'b0;
          state_d   = ST_SEND_REQ;
        end
      end
      ST_SEND_REQ: begin
        if (msg_ack_s) begin
          msg_req_d = 1'b0;
          state_d   = ST_SEND_REL;
        end
      end
      ST_SEND_REL: begin
        if (!msg_ack_s) begin
          byte_idx_d = (byte_idx_q == BYTE_LAST) ? '0 : byte_idx_q + 1'b1;
          if (!(last_q || pad_q)) begin
            state_d = ST_LOAD;
          end else if (byte_idx_q == BYTE_LAST) begin
            state_d = ST_HASH_WAIT;
          end else begin
            // Pad byte is loaded together with the rising request.
            ui_d      = '0;
            first_d   = 1'b0;
            last_d    = 1'b0;
            pad_d     = 1'b1;
            msg_req_d = 1'b1;
            state_d   = ST_SEND_REQ;
          end
        end
      end
      ST_HASH_WAIT: begin
        if (hash_req_s) begin
          // uo_out is stable while hash_req is high, so it is sampled raw.
          m_data_d   = dut_uo_i;
          m_valid_d  = 1'b1;
          m_last_d   = (hash_idx_q == HASH_LAST);
          hash_ack_d = 1'b1;
          state_d    = ST_HASH_ACK;
        end
      end
      ST_HASH_ACK: begin
        if (!hash_req_s) begin
          hash_ack_d = 1'b0;
          if (hash_idx_q == HASH_LAST) begin
            hash_idx_d = '0;
            byte_idx_d = '0;
            state_d    = ST_LOAD;
          end else begin
            hash_idx_d = hash_idx_q + 1'b1;
            state_d    = ST_HASH_WAIT;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (counting && (wd_q == '1)) begin
      timeout_d  = 1'b1;
      msg_req_d  = 1'b0;
      first_d    = 1'b0;
      last_d     = 1'b0;
      pad_d      = 1'b0;
      hash_ack_d = 1'b0;
      byte_idx_d = '0;
      hash_idx_d = '0;
      m_valid_d  = 1'b0;
      state_d    = ST_IDLE;
    end

    if (counting && (state_d == state_q)) begin
      wd_d = wd_q + 1'b1;
    end
  end

  // Assemble the host-owned uio bits; DUT-owned positions stay 0.
  always_comb begin
    uio_bus           = '0;
    uio_bus[MSG_REQ]  = msg_req_q;
    uio_bus[FIRST]    = first_q;
    uio_bus[LAST]     = last_q;
    uio_bus[PAD]      = pad_q;
    uio_bus[HASH_ACK] = hash_ack_q;
  end

  assign dut_uio_o    = uio_bus;
  assign dut_uio_oe_o = UIO_OE;
  assign dut_ui_o     = ui_q;
  assign s_ready_o    = (state_q == ST_LOAD);
  assign busy_o       = (state_q != ST_IDLE) && (state_q != ST_LOAD);
  assign m_valid_o    = m_valid_q;
  assign m_data_o     = m_data_q;
  assign m_last_o     = m_last_q;
  assign timeout_o    = timeout_q;

endmodule
